// File: rtl/machine_mode_types_pkg.sv
// Shared machine-mode trap types: exc_req bit positions, cause codes,
// trap sequencer states and the latched trap record.
package machine_mode_types_pkg;

    localparam int EXC_W = 9;

    // Bit positions inside exc_req
    typedef enum logic [3:0] {
        EXC_FAULT_INSN   = 4'd0,
        EXC_MAL_INSN     = 4'd1,
        EXC_ILLEGAL_INSN = 4'd2,
        EXC_BREAKPOINT   = 4'd3,
        EXC_ENV_M        = 4'd4,
        EXC_MAL_L        = 4'd5,
        EXC_FAULT_L      = 4'd6,
        EXC_MAL_S        = 4'd7,
        EXC_FAULT_S      = 4'd8
    } exc_idx_t;

    // Exception cause codes (mcause with interrupt bit clear)
    typedef enum logic [3:0] {
        EX_MAL_INSN     = 4'd0,
        EX_FAULT_INSN   = 4'd1,
        EX_ILLEGAL_INSN = 4'd2,
        EX_BREAKPOINT   = 4'd3,
        EX_MAL_L        = 4'd4,
        EX_FAULT_L      = 4'd5,
        EX_MAL_S        = 4'd6,
        EX_FAULT_S      = 4'd7,
        EX_ENV_M        = 4'd11
    } ex_code_t;

    // Interrupt cause codes (mcause with interrupt bit set)
    typedef enum logic [3:0] {
        INT_SOFT  = 4'd3,
        INT_TIMER = 4'd7,
        INT_EXT   = 4'd11
    } int_code_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        COMMIT,
        REDIRECT
    } trap_state_t;

    // mie_mask bit positions: {meie, mtie, msie}
    localparam int MIE_MSIE = 0;
    localparam int MIE_MTIE = 1;
    localparam int MIE_MEIE = 2;

    // Trap record captured when a request is accepted
    typedef struct packed {
        logic       intr;
        logic       ret;
        logic [3:0] cause;
    } trap_rec_t;

    // Address-type exceptions that report a faulting address in mbadaddr
    function automatic logic has_badaddr(input logic [3:0] code);
        return (code == EX_MAL_INSN) || (code == EX_FAULT_INSN) ||
               (code == EX_MAL_L)    || (code == EX_FAULT_L)    ||
               (code == EX_MAL_S)    || (code == EX_FAULT_S);
    endfunction

endpackage

// File: rtl/prv_trap_prioritizer.sv
// Combinational arbiter: picks one of interrupt / exception / MRET and
// reports the winning cause code.
module prv_trap_prioritizer
    import machine_mode_types_pkg::*;
(
    input  logic [EXC_W-1:0] exc_req,
    input  logic             ret,
    input  logic             timer_int,
    input  logic             soft_int,
    input  logic             ext_int,
    input  logic             mstatus_mie,
    input  logic [2:0]       mie_mask,
    output logic             take,
    output logic             is_intr,
    output logic             is_ret,
    output logic [3:0]       cause
);

    logic ext_en, soft_en, timer_en;

    assign ext_en   = mstatus_mie & ext_int   & mie_mask[MIE_MEIE];
    assign soft_en  = mstatus_mie & soft_int  & mie_mask[MIE_MSIE];
    assign timer_en = mstatus_mie & timer_int & mie_mask[MIE_MTIE];

    // Enabled interrupts first, then exceptions in fixed order, then MRET
    always_comb begin
        take    = 1'b1;
        is_intr = 1'b0;
        is_ret  = 1'b0;
        cause   = 4'd0;
        if (ext_en) begin
            is_intr = 1'b1;
            cause   = INT_EXT;
        end else if (soft_en) begin
            is_intr = 1'b1;
            cause   = INT_SOFT;
        end else if (timer_en) begin
            is_intr = 1'b1;
            cause   = INT_TIMER;
        end else if (exc_req[EXC_BREAKPOINT]) begin
            cause = EX_BREAKPOINT;
        end else if (exc_req[EXC_FAULT_INSN]) begin
            cause = EX_FAULT_INSN;
        end else if (exc_req[EXC_MAL_INSN]) begin
            cause = EX_MAL_INSN;
        end else if (exc_req[EXC_ILLEGAL_INSN]) begin
            cause = EX_ILLEGAL_INSN;
        end else if (exc_req[EXC_ENV_M]) begin
            cause = EX_ENV_M;
        end else if (exc_req[EXC_MAL_L]) begin
            cause = EX_MAL_L;
        end else if (exc_req[EXC_FAULT_L]) begin
            cause = EX_FAULT_L;
        end else if (exc_req[EXC_MAL_S]) begin
            cause = EX_MAL_S;
        end else if (exc_req[EXC_FAULT_S]) begin
            cause = EX_FAULT_S;
        end else if (ret) begin
            is_ret = 1'b1;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap sequencer: accepts one request in IDLE, drains the
// pipeline, commits mepc/mcause/mbadaddr, then redirects fetch.
// Build option: PRV_VECTORED_TRAP_EN enables vectored interrupt targets
// when mtvec[1:0] == 2'b01; otherwise every trap goes to the base address.
module prv_trap_sequencer
    import machine_mode_types_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MIN_DRAIN = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [EXC_W-1:0] exc_req,
    input  logic             ret,
    input  logic [XLEN-1:0]  epc,
    input  logic [XLEN-1:0]  badaddr,
    input  logic             timer_int,
    input  logic             soft_int,
    input  logic             ext_int,
    input  logic             mstatus_mie,
    input  logic [2:0]       mie_mask,
    input  logic [XLEN-1:0]  mtvec,
    input  logic [XLEN-1:0]  mepc_r,
    input  logic             pipe_ready,
    output logic             pipe_clear,
    output logic             insert_pc,
    output logic [XLEN-1:0]  priv_pc,
    output logic             intr,
    output logic             csr_we,
    output logic [XLEN-1:0]  mcause_w,
    output logic [XLEN-1:0]  mepc_w,
    output logic [XLEN-1:0]  mbadaddr_w,
    output logic             mie_push,
    output logic             mie_pop,
    output logic             busy
);

    // Counter value at which the minimum drain time has elapsed
    localparam logic [3:0] DRAIN_LAST = 4'(MIN_DRAIN - 1);

    trap_state_t     state, state_nx;
    logic            sel_take, sel_intr, sel_ret;
    logic [3:0]      sel_cause;
    logic            accept;
    logic [3:0]      drain_cnt;
    trap_rec_t       rec_q;
    logic [XLEN-1:0] epc_q, badaddr_q, target_q;
    logic [XLEN-1:0] trap_base, trap_tgt;

    prv_trap_prioritizer u_prio (
        .exc_req     (exc_req),
        .ret         (ret),
        .timer_int   (timer_int),
        .soft_int    (soft_int),
        .ext_int     (ext_int),
        .mstatus_mie (mstatus_mie),
        .mie_mask    (mie_mask),
        .take        (sel_take),
        .is_intr     (sel_intr),
        .is_ret      (sel_ret),
        .cause       (sel_cause)
    );

    assign accept    = (state == IDLE) && sel_take;
    // Mode bits are masked off; the base is always word aligned
    assign trap_base = mtvec & {{(XLEN-2){1'b1}}, 2'b00};

`ifdef PRV_VECTORED_TRAP_EN
    assign trap_tgt = (sel_intr && (mtvec[1:0] == 2'b01))
                    ? trap_base + {{(XLEN-6){1'b0}}, sel_cause, 2'b00}
                    : trap_base;
`else
    assign trap_tgt = trap_base;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Trap record, target and drain counter; captured on IDLE->DRAIN
    always_ff @(posedge CLK) begin
        if (RST) begin
            rec_q     <= '0;
            epc_q     <= '0;
            badaddr_q <= '0;
            target_q  <= '0;
            drain_cnt <= '0;
        end else if (accept) begin
            rec_q     <= '{intr: sel_intr, ret: sel_ret, cause: sel_cause};
            epc_q     <= epc;
            badaddr_q <= badaddr;
            target_q  <= trap_tgt;
            drain_cnt <= '0;
        end else if ((state == DRAIN) && (drain_cnt != 4'hF)) begin
            drain_cnt <= drain_cnt + 4'd1;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        state_nx   = state;
        pipe_clear = 1'b0;
        busy       = 1'b0;
        insert_pc  = 1'b0;
        priv_pc    = '0;
        intr       = 1'b0;
        csr_we     = 1'b0;
        mcause_w   = '0;
        mepc_w     = '0;
        mbadaddr_w = '0;
        mie_push   = 1'b0;
        mie_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_take) state_nx = DRAIN;
            end
            DRAIN: begin
                pipe_clear = 1'b1;
                busy       = 1'b1;
                if ((drain_cnt >= DRAIN_LAST) && pipe_ready) state_nx = COMMIT;
            end
            COMMIT: begin
                pipe_clear = 1'b1;
                busy       = 1'b1;
                state_nx   = REDIRECT;
                if (rec_q.ret) begin
                    mie_pop = 1'b1;
                end else begin
                    csr_we     = 1'b1;
                    mie_push   = 1'b1;
                    mcause_w   = {rec_q.intr, {(XLEN-5){1'b0}}, rec_q.cause};
                    mepc_w     = epc_q;
                    mbadaddr_w = (!rec_q.intr && has_badaddr(rec_q.cause))
                               ? badaddr_q : '0;
                end
            end
            REDIRECT: begin
                pipe_clear = 1'b1;
                busy       = 1'b1;
                insert_pc  = 1'b1;
                intr       = rec_q.intr;
                // MRET reads mepc live so it sees any earlier CSR write
                priv_pc    = rec_q.ret ? mepc_r : target_q;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Bench for prv_trap_sequencer: directed vector table, hand-written stall
// and reset sequences, then randomized traffic against a timestamp model.
module tb_prv_trap_sequencer;
    import machine_mode_types_pkg::*;

    localparam int XLEN      = 32;
    localparam int MIN_DRAIN = 2;

`ifdef PRV_VECTORED_TRAP_EN
    localparam logic [31:0] EXT_VEC_PC = 32'h12C;
    localparam bit          VECTORED   = 1'b1;
`else
    localparam logic [31:0] EXT_VEC_PC = 32'h100;
    localparam bit          VECTORED   = 1'b0;
`endif

    // Reference priority tables: interrupts {ints bit, mask bit, code}
    localparam int INT_LINE [3] = '{2, 1, 0};
    localparam int INT_MASK [3] = '{2, 0, 1};
    localparam int INT_CODE [3] = '{11, 3, 7};
    localparam int EXC_BIT  [9] = '{3, 0, 1, 2, 4, 5, 6, 7, 8};
    localparam int EXC_CODE [9] = '{3, 1, 0, 2, 11, 4, 5, 6, 7};

    logic             CLK, RST;
    logic [8:0]       exc_req;
    logic             ret, timer_int, soft_int, ext_int, mstatus_mie, pipe_ready;
    logic [2:0]       mie_mask;
    logic [XLEN-1:0]  epc, badaddr, mtvec, mepc_r;
    logic             pipe_clear, insert_pc, intr, csr_we, mie_push, mie_pop, busy;
    logic [XLEN-1:0]  priv_pc, mcause_w, mepc_w, mbadaddr_w;

    prv_trap_sequencer #(.XLEN(XLEN), .MIN_DRAIN(MIN_DRAIN)) dut (
        .CLK(CLK), .RST(RST), .exc_req(exc_req), .ret(ret), .epc(epc),
        .badaddr(badaddr), .timer_int(timer_int), .soft_int(soft_int),
        .ext_int(ext_int), .mstatus_mie(mstatus_mie), .mie_mask(mie_mask),
        .mtvec(mtvec), .mepc_r(mepc_r), .pipe_ready(pipe_ready),
        .pipe_clear(pipe_clear), .insert_pc(insert_pc), .priv_pc(priv_pc),
        .intr(intr), .csr_we(csr_we), .mcause_w(mcause_w), .mepc_w(mepc_w),
        .mbadaddr_w(mbadaddr_w), .mie_push(mie_push), .mie_pop(mie_pop),
        .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic checkw(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic check1(input string nm, input int idx, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_req();
        exc_req = '0; ret = 0; timer_int = 0; soft_int = 0; ext_int = 0;
    endtask

    task automatic check_quiet(input string nm, input int idx);
        check1({nm, "_busy"}, idx, busy, 1'b0);
        check1({nm, "_clear"}, idx, pipe_clear, 1'b0);
        check1({nm, "_we"}, idx, csr_we, 1'b0);
        check1({nm, "_ins"}, idx, insert_pc, 1'b0);
        check1({nm, "_intr"}, idx, intr, 1'b0);
        check1({nm, "_push"}, idx, mie_push, 1'b0);
        check1({nm, "_pop"}, idx, mie_pop, 1'b0);
        checkw({nm, "_pc"}, idx, priv_pc, 32'h0);
        checkw({nm, "_mcause"}, idx, mcause_w, 32'h0);
        checkw({nm, "_mepc"}, idx, mepc_w, 32'h0);
        checkw({nm, "_mbad"}, idx, mbadaddr_w, 32'h0);
    endtask

    // Directed vector record: stimulus then expected commit/redirect values
    typedef struct {
        logic [8:0]  exc;
        logic        r;
        logic [2:0]  ints;   // {ext, soft, timer}
        logic        mie;
        logic [2:0]  mask;
        logic [31:0] pc, bad, tvec, mepc;
        logic [31:0] x_cause, x_mepc, x_bad, x_pc;
        logic        x_intr, x_ret;
    } vec_t;

    vec_t vt [12];

    // Behavioural arbiter straight from the priority lists
    function automatic void ref_pick(input logic [8:0] exc, input logic r, input logic [2:0] ints,
                                     input logic mie, input logic [2:0] mask,
                                     output bit take, output bit is_int, output bit is_r,
                                     output logic [3:0] code);
        take = 0; is_int = 0; is_r = 0; code = 0;
        for (int i = 0; i < 3; i++)
            if (!take && mie && ints[INT_LINE[i]] && mask[INT_MASK[i]]) begin
                take = 1; is_int = 1; code = 4'(INT_CODE[i]);
            end
        for (int i = 0; i < 9; i++)
            if (!take && exc[EXC_BIT[i]]) begin
                take = 1; code = 4'(EXC_CODE[i]);
            end
        if (!take && r) begin
            take = 1; is_r = 1;
        end
    endfunction

    // Timestamp model state
    int          cyc;
    bit          m_busy;
    int          m_t0, m_commit;
    bit          m_take, m_intr, m_ret;
    logic [3:0]  m_code;
    logic [31:0] m_epc, m_bad, m_tgt;

    initial begin
        clear_req();
        RST = 1; epc = 0; badaddr = 0; mstatus_mie = 0; mie_mask = 0;
        mtvec = 0; mepc_r = 0; pipe_ready = 1;

        vt[0]  = '{9'h004, 0, 3'b000, 0, 3'b000, 32'h200, 32'h0,    32'h100, 32'h0,
                   32'h2,        32'h200, 32'h0,    32'h100, 0, 0};
        vt[1]  = '{9'h020, 0, 3'b001, 1, 3'b111, 32'h210, 32'h33,   32'h100, 32'h0,
                   32'h80000007, 32'h210, 32'h0,    32'h100, 1, 0};
        vt[2]  = '{9'h000, 1, 3'b000, 0, 3'b000, 32'h0,   32'h0,    32'h100, 32'h404,
                   32'h0,        32'h0,   32'h0,    32'h404, 0, 1};
        vt[3]  = '{9'h000, 0, 3'b100, 1, 3'b111, 32'h220, 32'h0,    32'h101, 32'h0,
                   32'h8000000B, 32'h220, 32'h0,    EXT_VEC_PC, 1, 0};
        vt[4]  = '{9'h00A, 0, 3'b000, 0, 3'b000, 32'h300, 32'h55,   32'h100, 32'h0,
                   32'h3,        32'h300, 32'h0,    32'h100, 0, 0};
        vt[5]  = '{9'h120, 0, 3'b000, 0, 3'b000, 32'h304, 32'h1234, 32'h100, 32'h0,
                   32'h4,        32'h304, 32'h1234, 32'h100, 0, 0};
        vt[6]  = '{9'h040, 0, 3'b001, 0, 3'b111, 32'h308, 32'h77,   32'h100, 32'h0,
                   32'h5,        32'h308, 32'h77,   32'h100, 0, 0};
        vt[7]  = '{9'h000, 0, 3'b011, 1, 3'b111, 32'h30C, 32'h0,    32'h100, 32'h0,
                   32'h80000003, 32'h30C, 32'h0,    32'h100, 1, 0};
        vt[8]  = '{9'h000, 1, 3'b001, 1, 3'b101, 32'h0,   32'h0,    32'h100, 32'h500,
                   32'h0,        32'h0,   32'h0,    32'h500, 0, 1};
        vt[9]  = '{9'h010, 0, 3'b000, 0, 3'b000, 32'h400, 32'h99,   32'h100, 32'h0,
                   32'hB,        32'h400, 32'h0,    32'h100, 0, 0};
        vt[10] = '{9'h001, 0, 3'b000, 0, 3'b000, 32'h404, 32'hABC,  32'h203, 32'h0,
                   32'h1,        32'h404, 32'hABC,  32'h200, 0, 0};
        vt[11] = '{9'h080, 0, 3'b000, 0, 3'b000, 32'h408, 32'h44,   32'h101, 32'h0,
                   32'h6,        32'h408, 32'h44,   32'h100, 0, 0};

        tick(); tick();
        check_quiet("reset", 0);
        RST = 0;
        tick();
        check_quiet("post_reset", 0);

        // Directed vectors, pipe_ready held high
        for (int i = 0; i < 12; i++) begin
            exc_req = vt[i].exc; ret = vt[i].r;
            ext_int = vt[i].ints[2]; soft_int = vt[i].ints[1]; timer_int = vt[i].ints[0];
            mstatus_mie = vt[i].mie; mie_mask = vt[i].mask;
            epc = vt[i].pc; badaddr = vt[i].bad; mtvec = vt[i].tvec; mepc_r = vt[i].mepc;
            tick();                                     // edge 0 samples request
            clear_req(); epc = 32'hDEAD_0000; badaddr = 32'hBEEF_0000;
            check1("v_c1_clear", i, pipe_clear, 1'b1);
            check1("v_c1_busy", i, busy, 1'b1);
            check1("v_c1_we", i, csr_we, 1'b0);
            tick();
            check1("v_c2_clear", i, pipe_clear, 1'b1);
            check1("v_c2_we", i, csr_we, 1'b0);
            tick();
            check1("v_c3_we", i, csr_we, !vt[i].x_ret);
            check1("v_c3_push", i, mie_push, !vt[i].x_ret);
            check1("v_c3_pop", i, mie_pop, vt[i].x_ret);
            checkw("v_c3_mcause", i, mcause_w, vt[i].x_cause);
            checkw("v_c3_mepc", i, mepc_w, vt[i].x_mepc);
            checkw("v_c3_mbad", i, mbadaddr_w, vt[i].x_bad);
            check1("v_c3_ins", i, insert_pc, 1'b0);
            tick();
            check1("v_c4_ins", i, insert_pc, 1'b1);
            checkw("v_c4_pc", i, priv_pc, vt[i].x_pc);
            check1("v_c4_intr", i, intr, vt[i].x_intr);
            check1("v_c4_we", i, csr_we, 1'b0);
            check1("v_c4_clear", i, pipe_clear, 1'b1);
            tick();
            check_quiet("v_c5", i);
        end

        // Stall: fault_s with pipe_ready low for six cycles, new request ignored
        exc_req = 9'h100; epc = 32'h600; badaddr = 32'h66; mtvec = 32'h100;
        mstatus_mie = 0; pipe_ready = 0;
        tick();
        exc_req = 9'h004;
        for (int c = 1; c <= 6; c++) begin
            check1("stall_clear", c, pipe_clear, 1'b1);
            check1("stall_we", c, csr_we, 1'b0);
            if (c < 6) tick();
        end
        pipe_ready = 1;
        tick();
        exc_req = '0;
        check1("stall_we", 7, csr_we, 1'b1);
        checkw("stall_mcause", 7, mcause_w, 32'h7);
        checkw("stall_mepc", 7, mepc_w, 32'h600);
        checkw("stall_mbad", 7, mbadaddr_w, 32'h66);
        tick();
        check1("stall_ins", 8, insert_pc, 1'b1);
        checkw("stall_pc", 8, priv_pc, 32'h100);
        tick();
        check_quiet("stall_idle", 9);
        tick();
        check_quiet("stall_idle", 10);

        // Reset while in COMMIT
        exc_req = 9'h004; epc = 32'h700;
        tick();
        clear_req();
        tick(); tick();
        check1("rst_commit_we", 3, csr_we, 1'b1);
        RST = 1;
        tick();
        check_quiet("rst_abort", 4);
        RST = 0;
        tick();
        check_quiet("rst_abort", 5);

        // Randomized traffic against the timestamp model
        cyc = 0; m_busy = 0; m_t0 = 0; m_commit = -1;
        m_intr = 0; m_ret = 0; m_code = 0; m_epc = 0; m_bad = 0; m_tgt = 0;
        for (int it = 0; it < 800; it++) begin
            logic        e_busy, e_commit, e_redir;
            logic [31:0] base;
            bit          tk, ii, rr;
            logic [3:0]  cd;
            if (!m_busy) mtvec = $urandom;
            exc_req     = ($urandom_range(0, 3) == 0) ? 9'($urandom & $urandom) : 9'h0;
            ret         = ($urandom_range(0, 7) == 0);
            timer_int   = ($urandom_range(0, 5) == 0);
            soft_int    = ($urandom_range(0, 5) == 0);
            ext_int     = ($urandom_range(0, 5) == 0);
            mstatus_mie = 1'($urandom);
            mie_mask    = 3'($urandom);
            epc         = $urandom;
            badaddr     = $urandom;
            mepc_r      = $urandom;
            pipe_ready  = ($urandom_range(0, 9) < 7);
            RST         = ($urandom_range(0, 79) == 0);
            tick();
            cyc++;
            if (RST) begin
                m_busy = 0;
            end else if (m_busy && m_commit >= 0 && cyc == m_commit + 2) begin
                m_busy = 0;
            end else if (!m_busy) begin
                ref_pick(exc_req, ret, {ext_int, soft_int, timer_int}, mstatus_mie, mie_mask,
                         tk, ii, rr, cd);
                if (tk) begin
                    m_busy = 1; m_t0 = cyc; m_commit = -1;
                    m_intr = ii; m_ret = rr; m_code = cd;
                    m_epc = epc;
                    m_bad = (!ii && (cd inside {0, 1, 4, 5, 6, 7})) ? badaddr : 32'h0;
                    base  = {mtvec[31:2], 2'b00};
                    m_tgt = (VECTORED && ii && mtvec[1:0] == 2'b01) ? base + 32'(cd) * 4 : base;
                end
            end else if (m_commit < 0 && cyc >= m_t0 + MIN_DRAIN && pipe_ready) begin
                m_commit = cyc;
            end
            e_busy   = m_busy;
            e_commit = m_busy && m_commit >= 0 && cyc == m_commit;
            e_redir  = m_busy && m_commit >= 0 && cyc == m_commit + 1;
            check1("r_busy", cyc, busy, e_busy);
            check1("r_clear", cyc, pipe_clear, e_busy);
            check1("r_we", cyc, csr_we, e_commit && !m_ret);
            check1("r_push", cyc, mie_push, e_commit && !m_ret);
            check1("r_pop", cyc, mie_pop, e_commit && m_ret);
            checkw("r_mcause", cyc, mcause_w,
                   (e_commit && !m_ret) ? {m_intr, 27'h0, m_code} : 32'h0);
            checkw("r_mepc", cyc, mepc_w, (e_commit && !m_ret) ? m_epc : 32'h0);
            checkw("r_mbad", cyc, mbadaddr_w, (e_commit && !m_ret) ? m_bad : 32'h0);
            check1("r_ins", cyc, insert_pc, e_redir);
            check1("r_intr", cyc, intr, e_redir && m_intr);
            checkw("r_pc", cyc, priv_pc, e_redir ? (m_ret ? mepc_r : m_tgt) : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
